// File: rtl/mvm_stream_ctrl_if.sv
// Handshake and datapath-control bundle for the MVM streaming sequencer.
//   s_valid/s_ready         : input word stream (data travels on the datapath)
//   m_valid/m_ready/m_last  : y output stream (data comes from the datapath)
//   addr_a/wr_en_a          : mem_a address and write enable
//   addr_x/wr_en_x          : mem_x address and write enable
//   addr_y/wr_en_y          : mem_y address and write enable
//   clear_acc               : accumulator loads 0 at the next edge
// The master modport is the controller. The slave modport is the environment,
// which is the upstream source, the downstream consumer and the datapath.
interface mvm_stream_ctrl_if #(
  parameter int MAT_SCALE        = 4,
  parameter int VEC_MEM_SIZE_LOG = $clog2(MAT_SCALE),
  parameter int MAT_MEM_SIZE_LOG = $clog2(MAT_SCALE * MAT_SCALE)
);
  logic                        s_valid;
  logic                        s_ready;
  logic                        m_valid;
  logic                        m_ready;
  logic                        m_last;
  logic [MAT_MEM_SIZE_LOG-1:0] addr_a;
  logic                        wr_en_a;
  logic [VEC_MEM_SIZE_LOG-1:0] addr_x;
  logic                        wr_en_x;
  logic [VEC_MEM_SIZE_LOG-1:0] addr_y;
  logic                        wr_en_y;
  logic                        clear_acc;

  modport master (
    input  s_valid, m_ready,
    output s_ready, m_valid, m_last,
           addr_a, wr_en_a, addr_x, wr_en_x, addr_y, wr_en_y, clear_acc
  );

  modport slave (
    output s_valid, m_ready,
    input  s_ready, m_valid, m_last,
           addr_a, wr_en_a, addr_x, wr_en_x, addr_y, wr_en_y, clear_acc
  );
endinterface

// File: rtl/mvm_stream_ctrl.sv
// Streaming sequencer for the shared MVM datapath (mem_a, mem_x, mem_y, MAC, accumulator).
// The block accepts the matrix A as N*N words in row-major order, then the vector x as
// N words. It then runs the MAC loop and streams y[0..N-1] out. Only addresses and
// enables are driven from here. The data words go straight to and from the datapath.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; returns the block to INIT
//   bus   : mvm_stream_ctrl_if.master. It carries s_valid/s_ready,
//           m_valid/m_ready/m_last, addr_a/wr_en_a, addr_x/wr_en_x,
//           addr_y/wr_en_y and clear_acc.
module mvm_stream_ctrl #(
  parameter int MAT_SCALE        = 4,
  parameter int VEC_MEM_SIZE_LOG = $clog2(MAT_SCALE),
  parameter int MAT_MEM_SIZE_LOG = $clog2(MAT_SCALE * MAT_SCALE)
) (
  input  logic               clk,
  input  logic               reset,
  mvm_stream_ctrl_if.master  bus
);

  localparam logic [MAT_MEM_SIZE_LOG-1:0] A_LAST = MAT_MEM_SIZE_LOG'(MAT_SCALE * MAT_SCALE - 1);
  localparam logic [VEC_MEM_SIZE_LOG-1:0] V_LAST = VEC_MEM_SIZE_LOG'(MAT_SCALE - 1);

  typedef enum logic [2:0] {
    INIT,
    LOAD_A,
    LOAD_X,
    COMPUTE,
    DRAIN,
    OUT_RD,
    OUT_VAL
  } state_t;

  state_t                      state_q, state_d;
  logic [MAT_MEM_SIZE_LOG-1:0] a_q, a_d;
  logic [VEC_MEM_SIZE_LOG-1:0] x_q, x_d;
  logic [VEC_MEM_SIZE_LOG-1:0] y_q, y_d;

  // In COMPUTE the A and x counters double as c and c mod N. y_q counts the
  // completed rows, so it already holds c/N-1 when a row result is written.
  assign bus.addr_a = a_q;
  assign bus.addr_x = x_q;
  assign bus.addr_y = y_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      a_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    x_d           = x_q;
    y_d           = y_q;
    bus.s_ready   = 1'b0;
    bus.m_valid   = 1'b0;
    bus.m_last    = 1'b0;
    bus.wr_en_a   = 1'b0;
    bus.wr_en_x   = 1'b0;
    bus.wr_en_y   = 1'b0;
    bus.clear_acc = 1'b0;

    unique case (state_q)
      INIT: state_d = LOAD_A;

      LOAD_A: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) begin
          bus.wr_en_a = 1'b1;
          if (a_q == A_LAST) begin
            a_d     = '0;
            state_d = LOAD_X;
          end else begin
            a_d = a_q + MAT_MEM_SIZE_LOG'(1);
          end
        end
      end

      LOAD_X: begin
        bus.s_ready = 1'b1;
        if (bus.s_valid) begin
          bus.wr_en_x = 1'b1;
          if (x_q == V_LAST) begin
            x_d     = '0;
            state_d = COMPUTE;
          end else begin
            x_d = x_q + VEC_MEM_SIZE_LOG'(1);
          end
        end
      end

      // Reads lag addresses by one cycle. At the start of a row, add_out therefore
      // holds the finished previous row. The same cycle writes that row and clears acc.
      COMPUTE: begin
        bus.clear_acc = (x_q == '0);
        if (a_q != '0 && x_q == '0) begin
          bus.wr_en_y = 1'b1;
          y_d         = y_q + VEC_MEM_SIZE_LOG'(1);
        end
        x_d = (x_q == V_LAST) ? '0 : x_q + VEC_MEM_SIZE_LOG'(1);
        if (a_q == A_LAST) begin
          a_d     = '0;
          state_d = DRAIN;
        end else begin
          a_d = a_q + MAT_MEM_SIZE_LOG'(1);
        end
      end

      DRAIN: begin
        bus.wr_en_y   = 1'b1;
        bus.clear_acc = 1'b1;
        y_d           = '0;
        state_d       = OUT_RD;
      end

      OUT_RD: state_d = OUT_VAL;

      OUT_VAL: begin
        bus.m_valid = 1'b1;
        bus.m_last  = (y_q == V_LAST);
        if (bus.m_ready) begin
          if (y_q == V_LAST) begin
            y_d     = '0;
            a_d     = '0;
            x_d     = '0;
            state_d = LOAD_A;
          end else begin
            y_d     = y_q + VEC_MEM_SIZE_LOG'(1);
            state_d = OUT_RD;
          end
        end
      end

      default: state_d = INIT;
    endcase
  end

endmodule
